// File: rtl/z_sample_loader.sv
// Frame buffer for the ICA front end. It loads a channel-major DIM x SAMPLES frame,
// produces per-channel sums and serves registered random reads.
module z_sample_loader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DIM        = 5,
   parameter int unsigned SAMPLES    = 1024,
   parameter int unsigned LOGM       = 10,
   parameter int unsigned CH_W       = 3,
   parameter int unsigned SUM_WIDTH  = 42
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic                         load_data,
   input  logic                         serial_z_valid,
   input  logic signed [DATA_WIDTH-1:0] serial_z_in,
   input  logic                         rd_en,
   input  logic [CH_W-1:0]              rd_ch,
   input  logic [LOGM-1:0]              rd_addr,
   output logic signed [DATA_WIDTH-1:0] rd_data,
   output logic                         rd_valid,
   output logic                         loading,
   output logic                         load_done,
   output logic signed [SUM_WIDTH-1:0]  ch_sum,
   output logic [CH_W-1:0]              ch_sum_ch,
   output logic                         ch_sum_valid,
   output logic                         overrun
);

   localparam int unsigned ADDR_W = CH_W + LOGM;
   localparam int unsigned DEPTH  = DIM * SAMPLES;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                        state_q, state_d;
   logic [LOGM-1:0]               sample_cnt_q, sample_cnt_d;
   logic [CH_W-1:0]               ch_cnt_q, ch_cnt_d;
   logic signed [SUM_WIDTH-1:0]   acc_q, acc_d;
   logic signed [SUM_WIDTH-1:0]   ch_sum_q, ch_sum_d;
   logic [CH_W-1:0]               ch_sum_ch_q, ch_sum_ch_d;
   logic                          ch_sum_valid_q, ch_sum_valid_d;
   logic                          overrun_q, overrun_d;
   logic                          loading_q, loading_d;
   logic                          load_done_q, load_done_d;
   logic                          load_q;
   logic signed [DATA_WIDTH-1:0]  rd_data_q;
   logic                          rd_valid_q;

   logic                          reload_c;
   logic                          accept_c;
   logic [LOGM-1:0]               base_sample_c;
   logic [CH_W-1:0]               base_ch_c;
   logic signed [SUM_WIDTH-1:0]   base_acc_c;
   logic signed [SUM_WIDTH-1:0]   sum_c;
   logic [ADDR_W-1:0]             wr_addr_c;
   logic                          rd_ok_c;

   logic signed [DATA_WIDTH-1:0]  mem [DEPTH];

   // Next-state, counter and accumulator logic; a reload edge restarts from ch 0 / sample 0
   always_comb begin
      state_d        = state_q;
      sample_cnt_d   = sample_cnt_q;
      ch_cnt_d       = ch_cnt_q;
      acc_d          = acc_q;
      ch_sum_d       = ch_sum_q;
      ch_sum_ch_d    = ch_sum_ch_q;
      ch_sum_valid_d = 1'b0;
      overrun_d      = overrun_q;

      reload_c      = (state_q == DONE) && load_data && !load_q;
      accept_c      = load_data && serial_z_valid && ((state_q != DONE) || reload_c);
      base_sample_c = reload_c ? '0 : sample_cnt_q;
      base_ch_c     = reload_c ? '0 : ch_cnt_q;
      base_acc_c    = reload_c ? '0 : acc_q;
      sum_c         = base_acc_c + SUM_WIDTH'(serial_z_in);
      wr_addr_c     = {base_ch_c, base_sample_c};

      if (reload_c) begin
         state_d      = LOAD;
         sample_cnt_d = '0;
         ch_cnt_d     = '0;
         acc_d        = '0;
         overrun_d    = 1'b0;
      end else if ((state_q == DONE) && load_data && serial_z_valid) begin
         overrun_d = 1'b1;
      end

      if (accept_c) begin
         if (state_q == IDLE) begin
            state_d = LOAD;
         end
         sample_cnt_d = base_sample_c + LOGM'(1);
         acc_d        = sum_c;
         if (base_sample_c == LOGM'(SAMPLES - 1)) begin
            ch_cnt_d       = base_ch_c + CH_W'(1);
            acc_d          = '0;
            ch_sum_d       = sum_c;
            ch_sum_ch_d    = base_ch_c;
            ch_sum_valid_d = 1'b1;
            if (base_ch_c == CH_W'(DIM - 1)) begin
               state_d = DONE;
            end
         end
      end

      loading_d   = (state_d == LOAD);
      load_done_d = (state_d == DONE);
   end

   assign rd_ok_c = (rd_ch < CH_W'(DIM));

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q        <= IDLE;
         sample_cnt_q   <= '0;
         ch_cnt_q       <= '0;
         acc_q          <= '0;
         ch_sum_q       <= '0;
         ch_sum_ch_q    <= '0;
         ch_sum_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         loading_q      <= 1'b0;
         load_done_q    <= 1'b0;
         load_q         <= 1'b0;
         rd_data_q      <= '0;
         rd_valid_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         sample_cnt_q   <= sample_cnt_d;
         ch_cnt_q       <= ch_cnt_d;
         acc_q          <= acc_d;
         ch_sum_q       <= ch_sum_d;
         ch_sum_ch_q    <= ch_sum_ch_d;
         ch_sum_valid_q <= ch_sum_valid_d;
         overrun_q      <= overrun_d;
         loading_q      <= loading_d;
         load_done_q    <= load_done_d;
         load_q         <= load_data;
         rd_valid_q     <= rd_en;
         if (rd_en) begin
            rd_data_q <= rd_ok_c ? mem[{rd_ch, rd_addr}] : '0;
         end
      end
   end

   // Sample memory is never reset; a same-edge read sees the old word
   always_ff @(posedge clk) begin
      if (accept_c) begin
         mem[wr_addr_c] <= serial_z_in;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign loading      = loading_q;
   assign load_done    = load_done_q;
   assign ch_sum       = ch_sum_q;
   assign ch_sum_ch    = ch_sum_ch_q;
   assign ch_sum_valid = ch_sum_valid_q;
   assign overrun      = overrun_q;

endmodule
